// File: rtl/div_issue_ctrl.sv
// EX-stage initiator for the iterative divider start/annul/ready handshake.
// Holds operands steady while the divide runs, captures {rem,quot}, and releases the divider.
module div_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        div_req_i,
  input  logic        op_signed_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic        stall_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        stallreq_o,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        err_timeout_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          start_q, start_d;
  logic          annul_q, annul_d;
  logic          signed_q, signed_d;
  logic [31:0]   opData1_q, opData1_d;
  logic [31:0]   opData2_q, opData2_d;
  logic          hiloWe_q, hiloWe_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic          errTimeout_q, errTimeout_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      start_q      <= 1'b0;
      annul_q      <= 1'b0;
      signed_q     <= 1'b0;
      opData1_q    <= '0;
      opData2_q    <= '0;
      hiloWe_q     <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
      errTimeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      start_q      <= start_d;
      annul_q      <= annul_d;
      signed_q     <= signed_d;
      opData1_q    <= opData1_d;
      opData2_q    <= opData2_d;
      hiloWe_q     <= hiloWe_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      errTimeout_q <= errTimeout_d;
    end
  end

  // Annul is a one-cycle pulse, so it defaults low rather than holding.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    start_d      = start_q;
    annul_d      = 1'b0;
    signed_d     = signed_q;
    opData1_d    = opData1_q;
    opData2_d    = opData2_q;
    hiloWe_d     = hiloWe_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    errTimeout_d = errTimeout_q;

    case (state_q)
      IDLE: begin
        start_d  = 1'b0;
        hiloWe_d = 1'b0;
        if (div_req_i && !flush) begin
          opData1_d = reg1_i;
          opData2_d = reg2_i;
          signed_d  = op_signed_i;
          start_d   = 1'b1;
          count_d   = '0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        // Flush outranks a coincident ready: the result is dropped.
        if (flush) begin
          start_d  = 1'b0;
          annul_d  = 1'b1;
          hiloWe_d = 1'b0;
          state_d  = IDLE;
        end else if (div_ready_i) begin
          hi_d     = div_result_i[63:32];
          lo_d     = div_result_i[31:0];
          start_d  = 1'b0;
          hiloWe_d = 1'b1;
          state_d  = DONE;
        end else if (count_q == CW'(TIMEOUT_CYCLES - 1)) begin
          errTimeout_d = 1'b1;
          start_d      = 1'b0;
          annul_d      = 1'b1;
          hiloWe_d     = 1'b0;
          state_d      = IDLE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      DONE: begin
        start_d = 1'b0;
        if (flush || !stall_i) begin
          hiloWe_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        start_d  = 1'b0;
        hiloWe_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  assign stallreq_o = ((state_q == IDLE) && div_req_i && !flush) || (state_q == BUSY);

  assign div_start_o   = start_q;
  assign div_annul_o   = annul_q;
  assign div_signed_o  = signed_q;
  assign div_opdata1_o = opData1_q;
  assign div_opdata2_o = opData2_q;
  assign hilo_we_o     = hiloWe_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign err_timeout_o = errTimeout_q;

endmodule
